// File: rtl/aha_pd_sequencer.sv
// aha_pd_sequencer: power-domain on/off sequencer for clock enable, isolation and domain reset.
// Optional build macro AHA_PD_SEQ_IRQ_EN adds the DONE_IRQ completion pulse output.
module aha_pd_sequencer #(
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PWR_REQ,
    output logic       PWR_ACK,
    output logic       CLK_EN,
    output logic       ISO_EN,
    output logic       DOM_RESETn,
    output logic       BUSY,
    output logic [2:0] STATE
`ifdef AHA_PD_SEQ_IRQ_EN
    ,
    output logic       DONE_IRQ
`endif
);
    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PU_CLK = 3'd1,
        S_PU_RST = 3'd2,
        S_ON     = 3'd3,
        S_PD_ISO = 3'd4,
        S_PD_RST = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_done;

    assign w_done = r_cnt == CNT_W'(STEP_CYCLES - 1);

    // State register and dwell counter; counter restarts whenever the state changes
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || !BUSY) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Next state: stable states follow the request level, timed states run to completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OFF:    w_next = PWR_REQ ? S_PU_CLK : S_OFF;
            S_PU_CLK: w_next = w_done ? S_PU_RST : S_PU_CLK;
            S_PU_RST: w_next = w_done ? S_ON : S_PU_RST;
            S_ON:     w_next = PWR_REQ ? S_ON : S_PD_ISO;
            S_PD_ISO: w_next = w_done ? S_PD_RST : S_PD_ISO;
            S_PD_RST: w_next = w_done ? S_OFF : S_PD_RST;
            default:  w_next = S_OFF;
        endcase
    end

    // Moore output decode from the state register; unused encodings look like OFF
    always_comb begin
        CLK_EN     = 1'b0;
        ISO_EN     = 1'b1;
        DOM_RESETn = 1'b0;
        PWR_ACK    = 1'b0;
        BUSY       = 1'b0;
        case (r_state)
            S_PU_CLK: begin
                CLK_EN = 1'b1;
                BUSY   = 1'b1;
            end
            S_PU_RST: begin
                CLK_EN     = 1'b1;
                DOM_RESETn = 1'b1;
                BUSY       = 1'b1;
            end
            S_ON: begin
                CLK_EN     = 1'b1;
                ISO_EN     = 1'b0;
                DOM_RESETn = 1'b1;
                PWR_ACK    = 1'b1;
            end
            S_PD_ISO: begin
                CLK_EN     = 1'b1;
                DOM_RESETn = 1'b1;
                PWR_ACK    = 1'b1;
                BUSY       = 1'b1;
            end
            S_PD_RST: begin
                CLK_EN  = 1'b1;
                PWR_ACK = 1'b1;
                BUSY    = 1'b1;
            end
            default: ;
        endcase
    end

    assign STATE = r_state;

`ifdef AHA_PD_SEQ_IRQ_EN
    logic r_irq;

    // One-cycle pulse in the first cycle of ON or OFF reached by completing a sequence
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_irq <= 1'b0;
        else         r_irq <= (r_state == S_PU_RST && w_next == S_ON) ||
                              (r_state == S_PD_RST && w_next == S_OFF);
    end

    assign DONE_IRQ = r_irq;
`endif
endmodule
